// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: request side carries the instruction
// fields, response side carries encoded words, their addresses and the illegal-op reporting.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_illegal;
  logic [7:0]  err_count;

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_illegal, err_count
  );

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_illegal, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder feeding a 4-entry FIFO with running byte addresses.
// Define INSTR_ENC_ERRCNT_EN to enable the saturating illegal-request counter on err_count.
module instr_encoder (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);
  localparam int unsigned Depth = 4;

  logic [31:0] mem_q [Depth];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  count_q;
  logic [2:0]  count_d;
  logic [31:0] addr_q;
  logic        err_q;

  logic        legal;
  logic [31:0] enc;
  logic        accept;
  logic        push;
  logic        pop;
  logic        illegal;

  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (bus.in_op)
      3'd0: enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_funct};
      3'd1: enc = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd2: enc = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd3: enc = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd4: enc = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      default: legal = 1'b0;
    endcase
  end

  assign bus.in_ready  = (count_q < 3'd4);
  assign bus.out_valid = (count_q != 3'd0);
  assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign bus.out_addr  = addr_q;
  assign bus.err_illegal = err_q;

  // Illegal requests still consume a handshake but never reach the FIFO.
  assign accept  = bus.in_valid & bus.in_ready;
  assign push    = accept & legal;
  assign illegal = accept & ~legal;
  assign pop     = bus.out_valid & bus.out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      addr_q   <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= illegal;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
        addr_q   <= addr_q + 32'd4;
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= enc;
    end
  end

`ifdef INSTR_ENC_ERRCNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= 8'h00;
    end else if (illegal && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, FIFO fill/drain, illegal ops,
// mid-stream reset and address wrap.
module tb_instr_encoder;
  logic clk;
  logic reset;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  localparam int NumVec = 8;
  vec_t vecs [NumVec];

  int nvec;
  int nerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input int i);
    bus.in_valid = 1'b1;
    bus.in_op    = vecs[i].op;
    bus.in_rs    = vecs[i].rs;
    bus.in_rt    = vecs[i].rt;
    bus.in_rd    = vecs[i].rd;
    bus.in_funct = vecs[i].funct;
    bus.in_imm   = vecs[i].imm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    nvec = 0;
    nerr = 0;
    clk = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op = 3'd0;
    bus.in_rs = 5'd0;
    bus.in_rt = 5'd0;
    bus.in_rd = 5'd0;
    bus.in_funct = 6'd0;
    bus.in_imm = 16'd0;
    bus.out_ready = 1'b0;

    //          op    rs     rt     rd     funct   imm        expected word
    vecs[0] = '{3'd1, 5'd1,  5'd2,  5'd0,  6'h00, 16'h0005, 32'h20220005};
    vecs[1] = '{3'd0, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 32'h00221820};
    vecs[2] = '{3'd2, 5'd29, 5'd8,  5'd0,  6'h00, 16'h0010, 32'h8FA80010};
    vecs[3] = '{3'd3, 5'd2,  5'd3,  5'd0,  6'h00, 16'h1234, 32'hAC431234};
    vecs[4] = '{3'd4, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 32'h1022FFFF};
    vecs[5] = '{3'd0, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hABCD, 32'h03FFF83F};
    vecs[6] = '{3'd1, 5'd0,  5'd0,  5'd31, 6'h3F, 16'h8000, 32'h20008000};
    vecs[7] = '{3'd2, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0000, 32'h8FE00000};

    // Reset state
    do_reset();
    chk("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst out_instr", bus.out_instr, 32'h0);
    chk("rst out_addr", bus.out_addr, 32'h0);
    chk("rst err_illegal", {31'b0, bus.err_illegal}, 32'd0);
    chk("rst err_count", {24'b0, bus.err_count}, 32'd0);
    chk("rst in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Streaming table: each word visible one cycle after acceptance
    bus.out_ready = 1'b1;
    for (int i = 0; i < NumVec; i++) begin
      drive_vec(i);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("vec%0d out_instr", i), bus.out_instr, vecs[i].exp);
      chk($sformatf("vec%0d out_addr", i), bus.out_addr, 32'(4 * i));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("drained out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("drained out_instr", bus.out_instr, 32'h0);

    // Ordering through a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_vec(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("full in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order%0d instr", i), bus.out_instr, vecs[i].exp);
      chk($sformatf("order%0d addr", i), bus.out_addr, 32'(4 * i));
      @(negedge clk);
    end
    chk("order empty", {31'b0, bus.out_valid}, 32'd0);

    // Five beq with back-pressure
    do_reset();
    drive_vec(4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp accept%0d in_ready", k), {31'b0, bus.in_ready}, 32'd1);
      @(negedge clk);
    end
    chk("bp full in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bp held in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("bp stable instr", bus.out_instr, 32'h1022FFFF);
    chk("bp stable addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 1) chk("bp reopen in_ready", {31'b0, bus.in_ready}, 32'd1);
      if (j == 2) bus.in_valid = 1'b0;
      chk($sformatf("bp%0d valid", j), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("bp%0d instr", j), bus.out_instr, 32'h1022FFFF);
      chk($sformatf("bp%0d addr", j), bus.out_addr, 32'(4 * j));
      @(negedge clk);
    end
    chk("bp empty", {31'b0, bus.out_valid}, 32'd0);

    // Illegal ops
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = 3'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ill%0d err_illegal", k), {31'b0, bus.err_illegal}, 32'd1);
      chk($sformatf("ill%0d out_valid", k), {31'b0, bus.out_valid}, 32'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ill pulse ends", {31'b0, bus.err_illegal}, 32'd0);
`ifdef INSTR_ENC_ERRCNT_EN
    exp_cnt = 8'd3;
`else
    exp_cnt = 8'd0;
`endif
    chk("ill err_count", {24'b0, bus.err_count}, {24'b0, exp_cnt});
    chk("ill addr", bus.out_addr, 32'h0);

    // Mid-stream reset discards buffered words and same-cycle handshakes
    do_reset();
    drive_vec(0);
    @(negedge clk);
    drive_vec(1);
    @(negedge clk);
    chk("mid buffered valid", {31'b0, bus.out_valid}, 32'd1);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive_vec(2);
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid out_addr", bus.out_addr, 32'h0);
    chk("mid in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("mid out_instr", bus.out_instr, 32'h0);
    drive_vec(2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid repush instr", bus.out_instr, vecs[2].exp);
    chk("mid repush addr", bus.out_addr, 32'h0);
    @(negedge clk);

    // Address wrap via hierarchical preset
    do_reset();
    dut.addr_q = 32'hFFFF_FFFC;
    bus.out_ready = 1'b1;
    drive_vec(3);
    @(negedge clk);
    chk("wrap first addr", bus.out_addr, 32'hFFFF_FFFC);
    chk("wrap first instr", bus.out_instr, vecs[3].exp);
    drive_vec(5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("wrap next addr", bus.out_addr, 32'h0);
    chk("wrap next instr", bus.out_instr, vecs[5].exp);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
